// File: rtl/step_phase_decoder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | step_phase_decoder_if : stepper phase bus and decoded outputs     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface step_phase_decoder_if #(
  parameter int POS_W = 16
);
  logic [3:0]              phase_in;
  logic                    zero_cal;
  logic                    err_clr;
  logic signed [POS_W-1:0] position;
  logic                    step_pulse;
  logic                    dir_right;
  logic                    moving;
  logic                    at_left;
  logic                    at_right;
  logic                    locked;
  logic                    err_skip;
  logic                    err_invalid;
  logic [23:0]             step_period;

  modport master (
    output phase_in, zero_cal, err_clr,
    input  position, step_pulse, dir_right, moving, at_left, at_right,
           locked, err_skip, err_invalid, step_period
  );

  modport slave (
    input  phase_in, zero_cal, err_clr,
    output position, step_pulse, dir_right, moving, at_left, at_right,
           locked, err_skip, err_invalid, step_period
  );
endinterface
`default_nettype wire

// File: rtl/step_phase_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | step_phase_decoder : half-step phase bus -> position/dir/status   |
// | Optional step-period timer enabled by STEP_DEC_PERIOD_EN.         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module step_phase_decoder #(
  parameter int POS_W       = 16,
  parameter int LIMIT_POS   = 75,
  parameter int IDLE_CYCLES = 2_000_000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  step_phase_decoder_if.slave bus
);

  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic signed [POS_W-1:0] POS_MAX   = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN   = -POS_MAX;
  localparam logic signed [POS_W-1:0] LIM_P     = POS_W'(LIMIT_POS);
  localparam logic signed [POS_W-1:0] LIM_N     = -LIM_P;
  localparam logic [IDLE_W-1:0]       IDLE_LOAD = IDLE_W'(IDLE_CYCLES);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACKING = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  function automatic logic is_valid(input logic [3:0] p);
    case (p)
      4'b1000, 4'b1100, 4'b0100, 4'b0110,
      4'b0010, 4'b0011, 4'b0001, 4'b1001: is_valid = 1'b1;
      default:                            is_valid = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] pat_idx(input logic [3:0] p);
    case (p)
      4'b1100: pat_idx = 3'd1;
      4'b0100: pat_idx = 3'd2;
      4'b0110: pat_idx = 3'd3;
      4'b0010: pat_idx = 3'd4;
      4'b0011: pat_idx = 3'd5;
      4'b0001: pat_idx = 3'd6;
      4'b1001: pat_idx = 3'd7;
      default: pat_idx = 3'd0;
    endcase
  endfunction

  logic [3:0]              sync1_q, sync1_d;
  logic [3:0]              phase_s_q, phase_s_d;
  logic [3:0]              prev_s_q, prev_s_d;
  state_t                  state_q, state_d;
  logic signed [POS_W-1:0] position_q, position_d;
  logic                    step_pulse_q, step_pulse_d;
  logic                    dir_right_q, dir_right_d;
  logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic                    moving_q, moving_d;
  logic                    locked_q, locked_d;
  logic                    err_skip_q, err_skip_d;
  logic                    err_invalid_q, err_invalid_d;
  logic [2:0]              delta;
  logic                    step_r, step_l, step;

  always_comb begin
    sync1_d       = bus.phase_in;
    phase_s_d     = sync1_q;
    prev_s_d      = phase_s_q;
    state_d       = state_q;
    position_d    = position_q;
    dir_right_d   = dir_right_q;
    err_skip_d    = err_skip_q;
    err_invalid_d = err_invalid_q;
    step_r        = 1'b0;
    step_l        = 1'b0;
    // Mod-8 wrap of the 3-bit difference gives the signed index step directly.
    delta         = pat_idx(phase_s_q) - pat_idx(prev_s_q);

    case (state_q)
      ST_UNLOCKED: begin
        if (phase_s_q != 4'b0000) begin
          if (is_valid(phase_s_q)) begin
            state_d = ST_TRACKING;
          end else begin
            err_invalid_d = 1'b1;
            state_d       = ST_FAULT;
          end
        end
      end
      ST_TRACKING: begin
        if (phase_s_q == 4'b0000) begin
          state_d = ST_UNLOCKED;
        end else if (!is_valid(phase_s_q)) begin
          err_invalid_d = 1'b1;
          state_d       = ST_FAULT;
        end else if (delta == 3'd1) begin
          step_r = 1'b1;
        end else if (delta == 3'd7) begin
          step_l = 1'b1;
        end else if (delta != 3'd0) begin
          err_skip_d = 1'b1;
          state_d    = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (bus.err_clr) begin
          err_skip_d    = 1'b0;
          err_invalid_d = 1'b0;
          state_d       = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase

    step = step_r | step_l;
    if (step) begin
      dir_right_d = step_r;
    end
    if (step_r && (position_q != POS_MAX)) begin
      position_d = position_q + POS_W'(1);
    end else if (step_l && (position_q != POS_MIN)) begin
      position_d = position_q - POS_W'(1);
    end
    if (bus.zero_cal) begin
      position_d = '0;
    end

    step_pulse_d = step;
    if (step) begin
      idle_cnt_d = IDLE_LOAD;
    end else if (idle_cnt_q != '0) begin
      idle_cnt_d = idle_cnt_q - IDLE_W'(1);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
    moving_d = (idle_cnt_d != '0);
    locked_d = (state_d == ST_TRACKING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= '0;
      phase_s_q     <= '0;
      prev_s_q      <= '0;
      state_q       <= ST_UNLOCKED;
      position_q    <= '0;
      step_pulse_q  <= 1'b0;
      dir_right_q   <= 1'b0;
      idle_cnt_q    <= '0;
      moving_q      <= 1'b0;
      locked_q      <= 1'b0;
      err_skip_q    <= 1'b0;
      err_invalid_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      phase_s_q     <= phase_s_d;
      prev_s_q      <= prev_s_d;
      state_q       <= state_d;
      position_q    <= position_d;
      step_pulse_q  <= step_pulse_d;
      dir_right_q   <= dir_right_d;
      idle_cnt_q    <= idle_cnt_d;
      moving_q      <= moving_d;
      locked_q      <= locked_d;
      err_skip_q    <= err_skip_d;
      err_invalid_q <= err_invalid_d;
    end
  end

`ifdef STEP_DEC_PERIOD_EN
  logic [23:0] per_cnt_q, per_cnt_d;
  logic [23:0] step_period_q, step_period_d;
  logic        have_step_q, have_step_d;
  logic        lock_evt;

  // The counter restarts at 1 on a step so the next step reads the exact edge spacing.
  always_comb begin
    lock_evt      = (state_q == ST_UNLOCKED) && (state_d == ST_TRACKING);
    per_cnt_d     = (per_cnt_q == 24'hFF_FFFF) ? per_cnt_q : per_cnt_q + 24'd1;
    step_period_d = step_period_q;
    have_step_d   = have_step_q;
    if (lock_evt) begin
      have_step_d = 1'b0;
    end
    if (step) begin
      per_cnt_d   = 24'd1;
      have_step_d = 1'b1;
      if (have_step_q) begin
        step_period_d = per_cnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_q     <= '0;
      step_period_q <= '0;
      have_step_q   <= 1'b0;
    end else begin
      per_cnt_q     <= per_cnt_d;
      step_period_q <= step_period_d;
      have_step_q   <= have_step_d;
    end
  end

  assign bus.step_period = step_period_q;
`else
  assign bus.step_period = 24'd0;
`endif

  assign bus.position    = position_q;
  assign bus.step_pulse  = step_pulse_q;
  assign bus.dir_right   = dir_right_q;
  assign bus.moving      = moving_q;
  assign bus.at_left     = (position_q <= LIM_N);
  assign bus.at_right    = (position_q >= LIM_P);
  assign bus.locked      = locked_q;
  assign bus.err_skip    = err_skip_q;
  assign bus.err_invalid = err_invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_step_phase_decoder.sv
`default_nettype none
// tb_step_phase_decoder: directed vector table, hand sequences and a
// cycle-accurate behavioural model checked on every clock.
module tb_step_phase_decoder;

  localparam int POS_W = 8;
  localparam int LIMIT = 75;
  localparam int IDLE  = 50;
  localparam int PMAX  = 127;
  localparam int M_UNL = 0;
  localparam int M_TRK = 1;
  localparam int M_FLT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc = 0;
  int   pulse_cnt = 0;
  int   last_pulse_cyc = 0;

  step_phase_decoder_if #(.POS_W(POS_W)) bus ();

  step_phase_decoder #(
    .POS_W(POS_W), .LIMIT_POS(LIMIT), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #10 clk = ~clk;

  logic [3:0] pat [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

  // ---------------- behavioural reference model ----------------
  int         m_mode, m_pos, m_dir, m_pulse, m_skip, m_inv;
  int         m_cyc, m_have, m_last, m_any_last, m_period;
  logic [3:0] hist [4];

  function automatic int find_idx(input logic [3:0] p);
    for (int i = 0; i < 8; i++) if (pat[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_UNL; m_pos = 0; m_dir = 0; m_pulse = 0; m_skip = 0; m_inv = 0;
    m_cyc = 0; m_have = 0; m_last = 0; m_any_last = -IDLE - 1; m_period = 0;
    for (int i = 0; i < 4; i++) hist[i] = 4'b0000;
  endtask

  task automatic model_step(input logic [3:0] pin, input logic zc, input logic ec);
    int ni, oi, d;
    logic [3:0] ps, pv;
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = pin;
    ps = hist[2];
    pv = hist[3];
    m_cyc++;
    m_pulse = 0;
    ni = find_idx(ps);
    oi = find_idx(pv);
    if (m_mode == M_UNL) begin
      if (ps != 4'b0000) begin
        if (ni >= 0) begin m_mode = M_TRK; m_have = 0; end
        else begin m_inv = 1; m_mode = M_FLT; end
      end
    end else if (m_mode == M_TRK) begin
      if (ps == 4'b0000) m_mode = M_UNL;
      else if (ni < 0) begin m_inv = 1; m_mode = M_FLT; end
      else begin
        d = (ni - oi + 8) % 8;
        if (d == 1) begin m_pulse = 1; m_dir = 1; m_pos = (m_pos + 1 > PMAX) ? PMAX : m_pos + 1; end
        else if (d == 7) begin m_pulse = 1; m_dir = 0; m_pos = (m_pos - 1 < -PMAX) ? -PMAX : m_pos - 1; end
        else if (d != 0) begin m_skip = 1; m_mode = M_FLT; end
      end
    end else if (ec) begin
      m_mode = M_UNL; m_skip = 0; m_inv = 0;
    end
    if (m_pulse != 0) begin
      if (m_have != 0) m_period = (m_cyc - m_last > 24'hFFFFFF) ? 24'hFFFFFF : m_cyc - m_last;
      m_have = 1;
      m_last = m_cyc;
      m_any_last = m_cyc;
    end
    if (zc) m_pos = 0;
  endtask

  task automatic check_model();
    logic [39:0] act, exp;
    logic [23:0] exp_per;
    logic [POS_W-1:0] exp_pos;
`ifdef STEP_DEC_PERIOD_EN
    exp_per = 24'(m_period);
`else
    exp_per = 24'd0;
`endif
    exp_pos = POS_W'(m_pos);
    act = {bus.position, bus.step_pulse, bus.dir_right, bus.moving, bus.at_left,
           bus.at_right, bus.locked, bus.err_skip, bus.err_invalid, bus.step_period};
    exp = {exp_pos, (m_pulse != 0), (m_dir != 0), (m_cyc - m_any_last < IDLE),
           (m_pos <= -LIMIT), (m_pos >= LIMIT), (m_mode == M_TRK),
           (m_skip != 0), (m_inv != 0), exp_per};
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model cyc=%0d actual=%h required=%h", cyc, act, exp);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(bus.phase_in, bus.zero_cal, bus.err_clr);
      @(negedge clk);
      cyc++;
      if (rst) model_reset();
      if (bus.step_pulse) begin pulse_cnt++; last_pulse_cyc = cyc; end
      check_model();
    end
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    logic [3:0] ph;
    logic       zc;
    logic       ec;
    int         pos;
    logic       lk, sk, iv, dr;
    int         np;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ph, input logic zc, input logic ec, input int pos,
                              input logic lk, input logic sk, input logic iv, input logic dr, input int np);
    vec_t v;
    v.ph = ph; v.zc = zc; v.ec = ec; v.pos = pos;
    v.lk = lk; v.sk = sk; v.iv = iv; v.dr = dr; v.np = np;
    return v;
  endfunction

  task automatic hand(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] p, input logic zc, input logic ec);
    @(posedge clk); #1;
    bus.phase_in = p; bus.zero_cal = zc; bus.err_clr = ec;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic apply(input vec_t v, input int n);
    logic [POS_W-1:0] ep;
    drive(v.ph, v.zc, v.ec);
    pulse_cnt = 0;
    drive(v.ph, v.zc, 1'b0);
    settle();
    ep = POS_W'(v.pos);
    hand($sformatf("table[%0d]", n),
         {bus.position, bus.locked, bus.err_skip, bus.err_invalid, bus.dir_right, 8'(pulse_cnt)},
         {ep, v.lk, v.sk, v.iv, v.dr, 8'(v.np)});
  endtask

  task automatic run_random(input int n_cyc);
    int r, ci;
    logic [3:0] p;
    logic [3:0] bad [7];
    bad = '{4'b1010, 4'b0101, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1111};
    ci = 0;
    for (int n = 0; n < n_cyc; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 799) == 0);
      r = $urandom_range(0, 99);
      if (r < 35)      p = pat[ci];
      else if (r < 65) begin ci = (ci + 1) % 8; p = pat[ci]; end
      else if (r < 85) begin ci = (ci + 7) % 8; p = pat[ci]; end
      else if (r < 89) p = 4'b0000;
      else if (r < 93) p = bad[$urandom_range(0, 6)];
      else begin ci = (ci + $urandom_range(2, 6)) % 8; p = pat[ci]; end
      bus.phase_in = p;
      bus.err_clr  = ($urandom_range(0, 5) == 0);
      bus.zero_cal = ($urandom_range(0, 29) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.err_clr = 1'b0; bus.zero_cal = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  vec_t tbl [18];
  initial begin
    int ci, n;
    bus.phase_in = 4'b0000; bus.zero_cal = 1'b0; bus.err_clr = 1'b0;

    tbl[0]  = mk(4'b1000, 0, 0, 0, 1, 0, 0, 0, 0);  // first valid pattern only locks
    tbl[1]  = mk(4'b1100, 0, 0, 1, 1, 0, 0, 1, 1);
    tbl[2]  = mk(4'b0100, 0, 0, 2, 1, 0, 0, 1, 1);
    tbl[3]  = mk(4'b0110, 0, 0, 3, 1, 0, 0, 1, 1);
    tbl[4]  = mk(4'b0000, 0, 0, 3, 0, 0, 0, 1, 0);  // unpowered: unlock, hold
    tbl[5]  = mk(4'b1000, 0, 0, 3, 1, 0, 0, 1, 0);
    tbl[6]  = mk(4'b1001, 0, 0, 2, 1, 0, 0, 0, 1);  // left
    tbl[7]  = mk(4'b0001, 0, 0, 1, 1, 0, 0, 0, 1);
    tbl[8]  = mk(4'b0100, 0, 0, 1, 0, 1, 0, 0, 0);  // skip of 4
    tbl[9]  = mk(4'b0110, 0, 0, 1, 0, 1, 0, 0, 0);  // ignored in fault
    tbl[10] = mk(4'b0110, 0, 1, 1, 1, 0, 0, 0, 0);  // clear then relock
    tbl[11] = mk(4'b0010, 0, 0, 2, 1, 0, 0, 1, 1);
    tbl[12] = mk(4'b1111, 0, 0, 2, 0, 0, 1, 1, 0);  // invalid
    tbl[13] = mk(4'b0000, 0, 0, 2, 0, 0, 1, 1, 0);
    tbl[14] = mk(4'b0000, 0, 1, 2, 0, 0, 0, 1, 0);
    tbl[15] = mk(4'b1000, 0, 0, 2, 1, 0, 0, 1, 0);
    tbl[16] = mk(4'b0000, 0, 0, 2, 0, 0, 0, 1, 0);
    tbl[17] = mk(4'b1000, 1, 0, 0, 1, 0, 0, 1, 0);  // lock with zero_cal

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    hand("reset_state",
         {bus.position, bus.step_pulse, bus.dir_right, bus.moving, bus.at_left, bus.at_right,
          bus.locked, bus.err_skip, bus.err_invalid, bus.step_period}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i], i);
`ifdef STEP_DEC_PERIOD_EN
      if (i == 3) hand("step_period", {40'd0, bus.step_period}, 64'd5);
`endif
    end

    // 75 right steps from zero: at_right on the 75th
    ci = 0;
    for (int k = 1; k <= 75; k++) begin
      ci = (ci + 1) % 8;
      drive(pat[ci], 1'b0, 1'b0);
      settle();
      if (k >= 74) hand($sformatf("limit_step%0d", k), {bus.position, bus.at_right, bus.at_left},
                        {POS_W'(k), (k >= 75), 1'b0});
    end
    drive(pat[ci], 1'b1, 1'b0);
    settle();
    hand("zero_cal", {bus.position, bus.at_right, bus.moving}, {POS_W'(0), 1'b0, 1'b1});
    drive(pat[ci], 1'b0, 1'b0);
    n = 0;
    while (bus.moving && n < IDLE + 20) begin
      @(negedge clk); #1;
      n++;
    end
    hand("moving_fall", {bus.moving, 32'(cyc - last_pulse_cyc)}, {1'b0, 32'(IDLE)});

    // saturation both ways, one step per cycle
    pulse_cnt = 0;
    for (int k = 0; k < 130; k++) begin ci = (ci + 1) % 8; drive(pat[ci], 1'b0, 1'b0); end
    settle();
    hand("sat_pos", {bus.position, bus.at_right, 16'(pulse_cnt)}, {POS_W'(PMAX), 1'b1, 16'd130});
    pulse_cnt = 0;
    for (int k = 0; k < 260; k++) begin ci = (ci + 7) % 8; drive(pat[ci], 1'b0, 1'b0); end
    settle();
    hand("sat_neg", {bus.position, bus.at_left, 16'(pulse_cnt)}, {POS_W'(-PMAX), 1'b1, 16'd260});

    // asynchronous reset mid-operation, then relock without counting
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    hand("async_rst", {bus.position, bus.locked, bus.at_left, bus.dir_right, bus.moving},
         {POS_W'(0), 4'b0000});
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    pulse_cnt = 0;
    settle();
    hand("relock", {bus.position, bus.locked, 8'(pulse_cnt)}, {POS_W'(0), 1'b1, 8'd0});

    run_random(3000);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_phase_decoder.md
# step_phase_decoder

Monitors the 4-bit half-step phase bus that drives the steering stepper and reconstructs the steering position, direction and motion status from it. Sits on the motor phase lines in parallel with the coil driver. Feeds the display and any steering-limit warning logic. Detects skipped or illegal phase patterns so a corrupted drive sequence is flagged rather than silently miscounted.

## Interface
- POS_W, 16: width of signed position output
- LIMIT_POS, 75: magnitude at which at_left / at_right assert
- IDLE_CYCLES, 2_000_000: cycles without a step before moving deasserts
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- phase_in  in  4  half-step phase bus, asynchronous to clk
- zero_cal  in  1  level; forces position to 0
- err_clr  in  1  pulse; clears FAULT
- position  out  POS_W  signed step count, +1 per right step
- step_pulse  out  1  one-cycle pulse per decoded step
- dir_right  out  1  direction of last decoded step, 1 = right
- moving  out  1  a step occurred within the last IDLE_CYCLES cycles
- at_left / at_right  out  1  position <= -LIMIT_POS / position >= LIMIT_POS
- locked  out  1  state is TRACKING
- err_skip  out  1  sticky; illegal index jump
- err_invalid  out  1  sticky; non-table pattern
- step_period  out  24  cycles between the last two steps

## Operation
- phase_in passes through a 2-FF synchronizer to phase_s. Decoding uses phase_s and the previous value, prev_s.
- Half-step table, index:pattern: 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
  - 0000 means the coil is unpowered. It is legal and not an error.
  - Any other pattern is invalid.
- Delta is computed mod 8 as new index minus old index:
  - +1 is a right step.
  - 7 (that is, -1) is a left step.
  - 0 is no step.
  - 2..6 is a skip.
- States:
  - UNLOCKED (reset state):
    - A valid pattern latches its index and moves to TRACKING. No step is counted.
    - 0000 stays in UNLOCKED.
    - An invalid pattern sets err_invalid and moves to FAULT.
  - TRACKING:
    - A step pulses step_pulse, sets dir_right and updates position by ±1.
    - 0000 moves to UNLOCKED. Position is held.
    - A skip sets err_skip and moves to FAULT.
    - An invalid pattern sets err_invalid and moves to FAULT.
  - FAULT:
    - Position is frozen and no steps are decoded.
    - err_clr moves to UNLOCKED and clears both error flags.
    - Errors are evaluated before err_clr; err_clr takes effect only in the cycle after the fault is flagged.
- Position saturates at ±(2^(POS_W-1)-1). A saturated step still pulses step_pulse.
- zero_cal has priority over a step in the same cycle:
  - position becomes 0.
  - step_pulse and dir_right still update.
- moving:
  - An idle counter is set to IDLE_CYCLES on each step and decrements to 0.
  - moving = (counter != 0).
- at_left and at_right are combinational from position, so they follow position with no extra latency.

## Timing
- Reset values:
  - position 0, step_pulse 0, dir_right 0, moving 0, at_left 0, at_right 0.
  - locked 0, err_skip 0, err_invalid 0, step_period 0.
  - Synchronizer flops and prev_s are 0000.
- Latency: a phase_in change that is stable before edge k updates all registered outputs at edge k+2, which is 3 edges including the capture edge.
- step_pulse is high for exactly one cycle per index change. A constant phase bus yields no pulses.
- rst asserted mid-operation returns everything to reset values immediately. The first valid pattern after reset only locks.

## Configuration
- STEP_DEC_PERIOD_EN defined:
  - A 24-bit cycle counter restarts at each step.
  - On each step after the first since locking, step_period is loaded with the count, saturating at 0xFFFFFF.
  - A direction reversal still counts as a step.
- STEP_DEC_PERIOD_EN undefined: the counter is absent and step_period is tied to 0.

## Test plan
- Reset, phase_in=0000: all outputs 0, locked=0. Then apply 1000: locked=1, position=0, no step_pulse.
- Apply 1000→1100→0100→0110 at 900_001-cycle spacing: three step_pulses, position=3, dir_right=1. With macro, step_period=900_001.
- Lock at 1000, apply 1001: position=-1, dir_right=0. Then 0001: position=-2.
- Apply 1000→0100 (a skip): err_skip=1, locked=0, position frozen. Further phases are ignored. err_clr, then 1000: locked=1.
- Apply 1111 while TRACKING: err_invalid=1, FAULT. Apply 0000 while TRACKING: locked=0, no error.
- Step right 75 times: at_right=1 on the 75th step. Assert zero_cal: position=0, at_right=0. Stop stepping: moving falls exactly IDLE_CYCLES cycles after the last step_pulse.
